// File: rtl/instr_seq_pkg.sv
// Shared configuration for the instruction sequencer: default widths,
// the sequencer state type and the packed instruction layout.
package instr_seq_pkg;

   localparam int DEF_INSTR_SIZE = 32;
   localparam int DEF_IBUFF_SIZE = 16;
   localparam int DEF_OPC_W      = 4;
   localparam int DEF_CNT_W      = 8;
   localparam int DEF_OPND_W     = DEF_INSTR_SIZE - 6 - DEF_CNT_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      BUSY  = 2'd2,
      HALT  = 2'd3
   } seq_state_t;

   // Instruction word at the default widths, LSB first: start, last, opcode,
   // repeat count, operand. 'repeat' is a keyword, hence 'rpt'.
   typedef struct packed {
      logic [DEF_OPND_W-1:0] operand;
      logic [DEF_CNT_W-1:0]  rpt;
      logic [DEF_OPC_W-1:0]  opc;
      logic                  last;
      logic                  start;
   } instr_t;

   // Build an instruction word at the default widths.
   function automatic logic [DEF_INSTR_SIZE-1:0] pack_instr(
      input logic                  start,
      input logic                  last,
      input logic [DEF_OPC_W-1:0]  opc,
      input logic [DEF_CNT_W-1:0]  rpt,
      input logic [DEF_OPND_W-1:0] operand
   );
      instr_t w;
      w.start   = start;
      w.last    = last;
      w.opc     = opc;
      w.rpt     = rpt;
      w.operand = operand;
      return w;
   endfunction

endpackage

// File: rtl/instr_seq_if.sv
// Host-write and tile-controller command signals of the sequencer.
//
// Handshake: a command transfers on every rising edge where cmd_valid and
// cmd_ready are both high. Once cmd_valid rises it stays high, with cmd_opc,
// cmd_operand and cmd_last unchanged, until that transfer; cmd_ready may be
// driven independently of cmd_valid. op_done is a one-cycle completion pulse
// for the last transferred command; wr_en pushes instr with no back-pressure
// other than full.
interface instr_seq_if
   import instr_seq_pkg::*;
#(
   parameter int INSTR_SIZE = DEF_INSTR_SIZE,
   parameter int OPC_W      = DEF_OPC_W,
   parameter int CNT_W      = DEF_CNT_W
) ();

   localparam int OPND_W = INSTR_SIZE - 6 - CNT_W;

   logic                  wr_en;
   logic [INSTR_SIZE-1:0] instr;
   logic                  full;
   logic                  empty;
   logic                  overflow;
   logic                  enable;
   logic                  restart;
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic [OPC_W-1:0]      cmd_opc;
   logic [OPND_W-1:0]     cmd_operand;
   logic                  cmd_last;
   logic                  op_done;
   logic                  seq_done;

   // Sequencer side.
   modport slave (
      input  wr_en, instr, enable, restart, cmd_ready, op_done,
      output full, empty, overflow, cmd_valid, cmd_opc, cmd_operand,
             cmd_last, seq_done
   );

   // Host and tile-controller side.
   modport master (
      output wr_en, instr, enable, restart, cmd_ready, op_done,
      input  full, empty, overflow, cmd_valid, cmd_opc, cmd_operand,
             cmd_last, seq_done
   );

endinterface

// File: rtl/instr_fifo.sv
// Show-ahead synchronous FIFO: o_dout is the head entry whenever o_empty is
// low. A push while full is dropped unless a pop happens in the same cycle,
// and a dropped push sets the sticky overflow flag.
module instr_fifo #(
   parameter int DEPTH  = 16,
   parameter int DWIDTH = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_wr_en,
   input  logic [DWIDTH-1:0] i_din,
   input  logic              i_rd_en,
   output logic [DWIDTH-1:0] o_dout,
   output logic              o_full,
   output logic              o_empty,
   output logic              o_overflow
);

   localparam int          AW      = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
   localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

   logic [DWIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [AW:0]       r_count;
   logic              r_overflow;

   logic w_full;
   logic w_empty;
   logic w_pop;
   logic w_push;

   assign w_full  = (r_count == CNT_MAX);
   assign w_empty = (r_count == '0);
   assign w_pop   = i_rd_en && !w_empty;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign w_push  = i_wr_en && (!w_full || w_pop);

   assign o_dout     = r_mem[r_rd_ptr];
   assign o_full     = w_full;
   assign o_empty    = w_empty;
   assign o_overflow = r_overflow;

   // Storage array; contents need no reset because occupancy guards reads.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_din;
      end
   end

   // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + CNT_ONE;
         end else if (w_pop && !w_push) begin
            r_count <= r_count - CNT_ONE;
         end
      end
   end

   // Sticky flag for a push that was dropped; only reset clears it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_overflow <= 1'b0;
      end else if (i_wr_en && !w_push) begin
         r_overflow <= 1'b1;
      end
   end

endmodule

// File: rtl/instr_seq.sv
// Instruction sequencer: fetches host instructions from a show-ahead FIFO,
// decodes them, issues each one repeat+1 times to the tile controller and
// halts after the instruction flagged 'last'.
module instr_seq
   import instr_seq_pkg::*;
#(
   parameter int INSTR_SIZE = DEF_INSTR_SIZE,
   parameter int IBUFF_SIZE = DEF_IBUFF_SIZE,
   parameter int OPC_W      = DEF_OPC_W,
   parameter int CNT_W      = DEF_CNT_W
) (
   input  logic       clk,
   input  logic       rst,
   instr_seq_if.slave bus,
   output seq_state_t o_dbg_state
);

   localparam int              OPND_W  = INSTR_SIZE - 6 - CNT_W;
   localparam logic [CNT_W-1:0] REP_ONE = CNT_W'(1);

   logic [INSTR_SIZE-1:0] w_head;
   logic                  w_empty;
   logic                  w_fetch;

   logic                  w_head_start;
   logic                  w_head_last;
   logic [OPC_W-1:0]      w_head_opc;
   logic [CNT_W-1:0]      w_head_rpt;
   logic [OPND_W-1:0]     w_head_opnd;

   seq_state_t            r_state;
   logic                  r_cmd_valid;
   logic                  r_seq_done;
   logic [OPC_W-1:0]      r_opc;
   logic [OPND_W-1:0]     r_operand;
   logic                  r_last;
   logic [CNT_W-1:0]      r_rep_cnt;

   instr_fifo #(
      .DEPTH  (IBUFF_SIZE),
      .DWIDTH (INSTR_SIZE)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .i_wr_en    (bus.wr_en),
      .i_din      (bus.instr),
      .i_rd_en    (w_fetch),
      .o_dout     (w_head),
      .o_full     (bus.full),
      .o_empty    (w_empty),
      .o_overflow (bus.overflow)
   );

   // Field decode of the FIFO head.
   assign w_head_start = w_head[0];
   assign w_head_last  = w_head[1];
   assign w_head_opc   = w_head[2 +: OPC_W];
   assign w_head_rpt   = w_head[6 +: CNT_W];
   assign w_head_opnd  = w_head[INSTR_SIZE-1 : 6+CNT_W];

   // Fetch from IDLE, or straight out of BUSY when the finished command was
   // neither repeating nor last, so consecutive commands have no idle gap.
   assign w_fetch = bus.enable && !w_empty &&
                    ((r_state == IDLE) ||
                     ((r_state == BUSY) && bus.op_done &&
                      (r_rep_cnt == '0) && !r_last));

   assign bus.empty       = w_empty;
   assign bus.cmd_valid   = r_cmd_valid;
   assign bus.cmd_opc     = r_opc;
   assign bus.cmd_operand = r_operand;
   assign bus.cmd_last    = r_last;
   assign bus.seq_done    = r_seq_done;
   assign o_dbg_state     = r_state;

   // Sequencer FSM with registered command outputs and repeat counter. The
   // fetch block after the case overrides the BUSY->IDLE default whenever a
   // back-to-back fetch is taken.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= IDLE;
         r_cmd_valid <= 1'b0;
         r_seq_done  <= 1'b0;
         r_opc       <= '0;
         r_operand   <= '0;
         r_last      <= 1'b0;
         r_rep_cnt   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
            end
            ISSUE: begin
               if (bus.cmd_ready) begin
                  r_state     <= BUSY;
                  r_cmd_valid <= 1'b0;
               end
            end
            BUSY: begin
               if (bus.op_done) begin
                  if (r_rep_cnt != '0) begin
                     r_rep_cnt   <= r_rep_cnt - REP_ONE;
                     r_state     <= ISSUE;
                     r_cmd_valid <= 1'b1;
                  end else if (r_last) begin
                     r_state    <= HALT;
                     r_seq_done <= 1'b1;
                  end else begin
                     r_state <= IDLE;
                  end
               end
            end
            HALT: begin
               if (bus.restart) begin
                  r_state    <= IDLE;
                  r_seq_done <= 1'b0;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase

         if (w_fetch) begin
            r_opc     <= w_head_opc;
            r_operand <= w_head_opnd;
            r_last    <= w_head_last;
            r_rep_cnt <= w_head_rpt;
            if (w_head_start) begin
               r_state     <= ISSUE;
               r_cmd_valid <= 1'b1;
            end else if (w_head_last) begin
               r_state    <= HALT;
               r_seq_done <= 1'b1;
            end else begin
               // start=0, last=0 is a NOP: consumed but never issued.
               r_state <= IDLE;
            end
         end
      end
   end

endmodule
